core_sequencer: RTL and testbench
=================================

Name: core_sequencer

Overview:
- Instruction generator for the 34-bit `inst` bus of `core`.
- On a `start` pulse, runs a full convolution pass for each kernel position kij:
  - weight fetch into L0
  - kernel load into the PE array
  - activation fetch
  - execute
  - output drain into pmem, with accumulation from kij=1 onward
- Sits between the testbench/host and `core`; owns every SRAM address and corelet control bit.

Parameters:
- row, 8, PE array rows (activation words per weight tile)
- col, 8, PE array columns (weight words per kernel tile)
- addr_bw, 11, xmem/pmem address width
- pad_cyc, 16, idle cycles after kernel load so weights settle (>= row+col)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- cfg_kij_num  in  4  number of kernel positions (0..15)
- cfg_nij_num  in  11  activations/outputs per kij
- cfg_w_base  in  11  xmem base of weight tiles; tile k at w_base + k*col
- cfg_x_base  in  11  xmem base of activations
- cfg_p_base  in  11  pmem base of psums
- ofifo_valid  in  1  from core; ofifo holds >=1 output row
- inst  out  34  to core: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] pmem_addr, [19] CEN_xmem, [18] WEN_xmem, [17:7] xmem_addr, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at end of pass

Behaviour:
- IDLE inst value: CEN_xmem=CEN_pmem=1, WEN_xmem=WEN_pmem=1, all other bits 0. Outputs are registered.
- Reset (async, active-low):
  - state=IDLE, inst=IDLE value, busy=0, done=0, all counters 0.
  - Reset mid-operation aborts immediately; no partial writes complete.
- Config latch: cfg_* is latched on the accepted start; later cfg changes have no effect on the running pass.
- Degenerate config: if cfg_kij_num==0 or cfg_nij_num==0 at start, pulse done on the next cycle with busy low and no SRAM access.
- start while busy is ignored.
- WFETCH, col cycles (i=0..col-1):
  - CEN_xmem=0, WEN_xmem=1, xmem_addr=w_base+kij*col+i.
  - l0_wr is asserted one cycle later than each read (1-cycle SRAM latency), so l0_wr overlaps the next state's first cycle.
- WLOAD, col cycles: l0_rd=1, load=1.
- WPAD, pad_cyc cycles: inst = IDLE value.
- XFETCH, nij cycles: xmem_addr=x_base+n, CEN_xmem=0; l0_wr delayed by one cycle as in WFETCH.
- EXEC, nij cycles: l0_rd=1, execute=1.
- DRAIN, two-cycle pattern per output n=0..nij-1:
  - Cycle A, entered only when ofifo_valid=1 (otherwise wait with IDLE inst):
    - ofifo_rd=1
    - if kij>0: CEN_pmem=0, WEN_pmem=1, pmem_addr=p_base+n (read old psum)
  - Cycle B:
    - CEN_pmem=0, WEN_pmem=0, pmem_addr=p_base+n
    - acc=(kij>0)
- NEXT: kij++. If kij==kij_num, go to DONE; otherwise go to WFETCH.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- All address sums truncate modulo 2^addr_bw (wrap; no error).
- ififo_wr and ififo_rd are always 0 (weight-stationary mode).
- Total cycles per kij, excluding ofifo stalls: col+1 + col + pad_cyc + nij+1 + nij + 2*nij.

Test Plan:
- Reset mid-EXEC (reset low for 2 cycles) -> inst==IDLE value asynchronously; busy=0; no done pulse; new start works normally.
- kij_num=1, nij=4, w_base=0, x_base=16, p_base=0, ofifo_valid tied 1:
  - xmem reads 0..7 then 16..19
  - 8 load cycles, 4 execute cycles
  - pmem writes to 0..3 with acc=0
  - done at cycle 8+1+8+16+5+4+8
- kij_num=3, nij=2, w_base=100:
  - weight tiles read at 100, 108, 116
  - kij 1 and 2: each pmem write is preceded by a read of the same address; acc=1
- ofifo_valid held 0 for 5 cycles in DRAIN -> no ofifo_rd and no pmem access during the stall; resumes at the same n.
- x_base=2046, nij=4 -> xmem_addr sequence 2046, 2047, 0, 1.
- start with nij=0 -> done next cycle, no CEN low; start pulsed again while busy -> ignored, pass count unchanged.

Source files
------------

// File: rtl/core_sequencer.sv
// Instruction sequencer for core: steps each kernel position through weight fetch/load,
// activation fetch, execute and psum drain, driving a registered inst bus.
module core_sequencer #(
  parameter int unsigned row     = 8,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_bw = 11,
  parameter int unsigned pad_cyc = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             cfg_kij_num,
  input  logic [addr_bw-1:0]     cfg_nij_num,
  input  logic [addr_bw-1:0]     cfg_w_base,
  input  logic [addr_bw-1:0]     cfg_x_base,
  input  logic [addr_bw-1:0]     cfg_p_base,
  input  logic                   ofifo_valid,
  output logic [2*addr_bw+11:0]  inst,
  output logic                   busy,
  output logic                   done
);

  localparam int unsigned InstW  = 2 * addr_bw + 12;
  localparam int unsigned CntW   = addr_bw + 1;
  // Weights need at least row+col cycles to ripple through the array.
  localparam int unsigned PadEff = (pad_cyc > row + col) ? pad_cyc : row + col;

  localparam logic [CntW-1:0]    ColEnd  = CntW'(col);
  localparam logic [CntW-1:0]    ColLast = CntW'(col - 1);
  localparam logic [CntW-1:0]    PadLast = CntW'(PadEff - 1);
  localparam logic [addr_bw-1:0] ColA    = addr_bw'(col);
  localparam logic [InstW-1:0]   InstIdle = {1'b0, 1'b1, 1'b1, {addr_bw{1'b0}},
                                             1'b1, 1'b1, {addr_bw{1'b0}}, 7'b0};

  typedef enum logic [3:0] {
    StIdle, StWFetch, StWLoad, StWPad, StXFetch, StExec,
    StDrainWait, StDrainA, StDrainB, StDone
  } state_e;

  state_e             state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [3:0]         kij_q, kij_d, kij_num_q, kij_num_d;
  logic [addr_bw-1:0] nij_q, nij_d, w_base_q, w_base_d, x_base_q, x_base_d, p_base_q, p_base_d;
  logic [InstW-1:0]   inst_q, inst_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic [CntW-1:0]    nij_ext, nij_last;
  assign nij_ext  = {1'b0, nij_q};
  assign nij_last = nij_ext - CntW'(1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kij_d     = kij_q;
    kij_num_d = kij_num_q;
    nij_d     = nij_q;
    w_base_d  = w_base_q;
    x_base_d  = x_base_q;
    p_base_d  = p_base_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          kij_num_d = cfg_kij_num;
          nij_d     = cfg_nij_num;
          w_base_d  = cfg_w_base;
          x_base_d  = cfg_x_base;
          p_base_d  = cfg_p_base;
          cnt_d     = '0;
          kij_d     = '0;
          state_d   = (cfg_kij_num == '0 || cfg_nij_num == '0) ? StDone : StWFetch;
        end
      end
      StWFetch: begin
        if (cnt_q == ColEnd) begin cnt_d = '0; state_d = StWLoad; end
        else cnt_d = cnt_q + CntW'(1);
      end
      StWLoad: begin
        if (cnt_q == ColLast) begin cnt_d = '0; state_d = StWPad; end
        else cnt_d = cnt_q + CntW'(1);
      end
      StWPad: begin
        if (cnt_q == PadLast) begin cnt_d = '0; state_d = StXFetch; end
        else cnt_d = cnt_q + CntW'(1);
      end
      StXFetch: begin
        if (cnt_q == nij_ext) begin cnt_d = '0; state_d = StExec; end
        else cnt_d = cnt_q + CntW'(1);
      end
      StExec: begin
        if (cnt_q == nij_last) begin
          cnt_d   = '0;
          state_d = ofifo_valid ? StDrainA : StDrainWait;
        end else cnt_d = cnt_q + CntW'(1);
      end
      StDrainWait: if (ofifo_valid) state_d = StDrainA;
      StDrainA:    state_d = StDrainB;
      StDrainB: begin
        if (cnt_q != nij_last) begin
          cnt_d   = cnt_q + CntW'(1);
          state_d = ofifo_valid ? StDrainA : StDrainWait;
        end else begin
          cnt_d = '0;
          if (kij_q == kij_num_q - 4'd1) state_d = StDone;
          else begin
            kij_d   = kij_q + 4'd1;
            state_d = StWFetch;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output fields are decoded from the next state so the inst register lines up with it.
  logic               acc, cen_p, wen_p, cen_x, wen_x, ofifo_rd, l0_rd, l0_wr, execute, load;
  logic [addr_bw-1:0] p_addr, x_addr, cnt_a, kij_a;
  assign cnt_a = cnt_d[addr_bw-1:0];
  assign kij_a = {{(addr_bw-4){1'b0}}, kij_d};

  always_comb begin
    acc = 1'b0; cen_p = 1'b1; wen_p = 1'b1; p_addr = '0;
    cen_x = 1'b1; wen_x = 1'b1; x_addr = '0;
    ofifo_rd = 1'b0; l0_rd = 1'b0; l0_wr = 1'b0; execute = 1'b0; load = 1'b0;
    unique case (state_d)
      StWFetch: begin
        if (cnt_d != ColEnd) begin
          cen_x  = 1'b0;
          x_addr = w_base_d + kij_a * ColA + cnt_a;
        end
        l0_wr = (cnt_d != '0);
      end
      StWLoad: begin l0_rd = 1'b1; load = 1'b1; end
      StXFetch: begin
        if (cnt_d != nij_ext) begin
          cen_x  = 1'b0;
          x_addr = x_base_d + cnt_a;
        end
        l0_wr = (cnt_d != '0);
      end
      StExec: begin l0_rd = 1'b1; execute = 1'b1; end
      StDrainA: begin
        ofifo_rd = 1'b1;
        if (kij_d != '0) begin cen_p = 1'b0; p_addr = p_base_d + cnt_a; end
      end
      StDrainB: begin
        cen_p = 1'b0; wen_p = 1'b0; p_addr = p_base_d + cnt_a;
        acc   = (kij_d != '0);
      end
      default: ;
    endcase
    inst_d = {acc, cen_p, wen_p, p_addr, cen_x, wen_x, x_addr,
              ofifo_rd, 1'b0, 1'b0, l0_rd, l0_wr, execute, load};
    busy_d = (state_d != StIdle) && (state_d != StDone);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      kij_q     <= '0;
      kij_num_q <= '0;
      nij_q     <= '0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      p_base_q  <= '0;
      inst_q    <= InstIdle;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kij_q     <= kij_d;
      kij_num_q <= kij_num_d;
      nij_q     <= nij_d;
      w_base_q  <= w_base_d;
      x_base_q  <= x_base_d;
      p_base_q  <= p_base_d;
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: expected SRAM accesses and done timing are queued
// per pass; a monitor decodes inst every cycle and checks against the queue.
module tb_core_sequencer;

  localparam logic [33:0] IdleInst = 34'h1_800C_0000;
  localparam int KXRd = 0, KXWr = 1, KPRd = 2, KPWr = 3, KDone = 4;

  logic        clk = 1'b0;
  logic        reset, start, ofifo_valid;
  logic [3:0]  cfg_kij_num;
  logic [10:0] cfg_nij_num, cfg_w_base, cfg_x_base, cfg_p_base;
  logic [33:0] inst;
  logic        busy, done;

  core_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_kij_num (cfg_kij_num),
    .cfg_nij_num (cfg_nij_num),
    .cfg_w_base  (cfg_w_base),
    .cfg_x_base  (cfg_x_base),
    .cfg_p_base  (cfg_p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct { int kind; int addr; int acc; } ev_t;
  ev_t exp_q[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0, start_cyc = 0, last_rel = 0;
  int n_load, n_exec, n_ord, n_l0rd, n_l0wr, n_ififo, n_done;
  bit saw_pwr = 0, stall_chk = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic push(input int kind, input int addr, input int acc);
    ev_t e;
    e.kind = kind; e.addr = addr; e.acc = acc;
    exp_q.push_back(e);
  endtask

  task automatic got_ev(input int kind, input int addr, input int acc);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL unexpected_event: got kind %0d addr %0d, expected no event", kind, addr);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.addr >= 0) chk("event_addr", addr, e.addr);
      if (e.kind == KPWr) chk("event_acc", acc, e.acc);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      last_rel = cyc - start_cyc;
      if (inst[19] == 1'b0) got_ev(inst[18] ? KXRd : KXWr, int'(inst[17:7]), 0);
      if (inst[32] == 1'b0) begin
        got_ev(inst[31] ? KPRd : KPWr, int'(inst[30:20]), int'(inst[33]));
        if (!inst[31]) saw_pwr = 1'b1;
      end
      if (done) begin got_ev(KDone, last_rel, 0); n_done++; end
      if (inst[0]) n_load++;
      if (inst[1]) n_exec++;
      if (inst[2]) n_l0wr++;
      if (inst[3]) n_l0rd++;
      if (inst[4] || inst[5]) n_ififo++;
      if (inst[6]) n_ord++;
      if (stall_chk && !ofifo_valid) begin
        chk("stall_ofifo_rd", inst[6], 0);
        chk("stall_cen_pmem", inst[32], 1);
      end
      cyc++;
    end
  end

  task automatic clear_counts();
    n_load = 0; n_exec = 0; n_ord = 0; n_l0rd = 0; n_l0wr = 0; n_ififo = 0; n_done = 0;
  endtask

  // Expected access stream for one pass (col = 8, 11-bit address wrap).
  task automatic push_pass(input int kn, input int nn, input int w, input int x, input int p,
                           input int done_rel);
    if (kn != 0 && nn != 0) begin
      for (int k = 0; k < kn; k++) begin
        for (int i = 0; i < 8; i++) push(KXRd, (w + k * 8 + i) % 2048, 0);
        for (int n = 0; n < nn; n++) push(KXRd, (x + n) % 2048, 0);
        for (int n = 0; n < nn; n++) begin
          if (k > 0) push(KPRd, (p + n) % 2048, 0);
          push(KPWr, (p + n) % 2048, (k > 0) ? 1 : 0);
        end
      end
    end
    push(KDone, done_rel, 0);
  endtask

  task automatic run_start(input int kn, input int nn, input int w, input int x, input int p);
    @(negedge clk);
    cfg_kij_num = 4'(kn); cfg_nij_num = 11'(nn);
    cfg_w_base = 11'(w); cfg_x_base = 11'(x); cfg_p_base = 11'(p);
    start = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int exp_done);
    int t = 0;
    while (n_done < exp_done && t < budget) begin @(negedge clk); t++; end
    if (n_done < exp_done) chk("done_timeout", n_done, exp_done);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int t;
    reset = 1'b0; start = 1'b0; ofifo_valid = 1'b1;
    cfg_kij_num = '0; cfg_nij_num = '0; cfg_w_base = '0; cfg_x_base = '0; cfg_p_base = '0;
    clear_counts();
    repeat (3) @(negedge clk);
    chk("reset_inst", inst, IdleInst);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b1;

    // Single kernel position, basic pass.
    clear_counts();
    push_pass(1, 4, 0, 16, 0, 50);
    run_start(1, 4, 0, 16, 0);
    chk("busy_after_start", busy, 1);
    wait_done(200, 1);
    chk("a_load", n_load, 8);
    chk("a_exec", n_exec, 4);
    chk("a_l0wr", n_l0wr, 12);
    chk("a_l0rd", n_l0rd, 12);
    chk("a_ofifo_rd", n_ord, 4);
    chk("a_ififo", n_ififo, 0);
    chk("a_busy_end", busy, 0);

    // Three kernel positions with accumulation; restart and cfg change mid-pass ignored.
    clear_counts();
    push_pass(3, 2, 100, 40, 8, 126);
    run_start(3, 2, 100, 40, 8);
    repeat (10) @(negedge clk);
    cfg_kij_num = 4'd1; cfg_nij_num = 11'd7; cfg_w_base = 11'd500;
    cfg_x_base = 11'd600; cfg_p_base = 11'd700;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(400, 1);
    repeat (5) @(negedge clk);
    chk("b_done_count", n_done, 1);
    chk("b_load", n_load, 24);
    chk("b_exec", n_exec, 6);
    chk("b_ofifo_rd", n_ord, 6);

    // ofifo stall of five cycles after the first psum write.
    clear_counts();
    saw_pwr = 1'b0;
    push_pass(1, 3, 0, 0, 20, 51);
    run_start(1, 3, 0, 0, 20);
    t = 0;
    while (!saw_pwr && t < 200) begin @(negedge clk); t++; end
    chk("stall_first_write_seen", saw_pwr, 1);
    ofifo_valid = 1'b0; stall_chk = 1'b1;
    repeat (5) @(negedge clk);
    ofifo_valid = 1'b1; stall_chk = 1'b0;
    wait_done(200, 1);
    chk("stall_ofifo_rd_total", n_ord, 3);

    // Activation address wrap at the top of xmem.
    clear_counts();
    push_pass(1, 4, 0, 2046, 0, 50);
    run_start(1, 4, 0, 2046, 0);
    wait_done(200, 1);

    // Degenerate configs finish immediately without SRAM access.
    clear_counts();
    push_pass(2, 0, 0, 0, 0, 0);
    run_start(2, 0, 0, 0, 0);
    chk("degen_nij_busy", busy, 0);
    wait_done(20, 1);
    clear_counts();
    push_pass(0, 5, 0, 0, 0, 0);
    run_start(0, 5, 0, 0, 0);
    chk("degen_kij_busy", busy, 0);
    wait_done(20, 1);

    // Asynchronous reset during execute aborts the pass.
    clear_counts();
    for (int i = 0; i < 8; i++) push(KXRd, i, 0);
    for (int n = 0; n < 4; n++) push(KXRd, 16 + n, 0);
    run_start(1, 4, 0, 16, 0);
    t = 0;
    while (last_rel < 39 && t < 200) begin @(negedge clk); t++; end
    chk("exec_reached", last_rel, 39);
    reset = 1'b0;
    #1;
    chk("async_reset_inst", inst, IdleInst);
    chk("async_reset_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_queue_empty", exp_q.size(), 0);
    chk("abort_no_done", n_done, 0);
    chk("abort_exec_cycles", n_exec, 2);

    clear_counts();
    push_pass(1, 4, 0, 16, 0, 50);
    run_start(1, 4, 0, 16, 0);
    wait_done(200, 1);
    chk("post_reset_exec", n_exec, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
